// File: rtl/repeat_pkg.sv
// repeat_pkg: shared state type and default count width for repeat_timer
package repeat_pkg;

    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

endpackage

// File: rtl/repeat_down_cnt.sv
// repeat_down_cnt: loadable down-counter with a one-before-zero detect
//   clk, rst       : clock, synchronous active-high reset
//   load, load_val : load a new count
//   clear          : force the count to zero (wins over load and dec)
//   dec            : decrement by one, holding at zero
//   cnt            : current count (registered)
//   last           : cnt == 1, so the next decrement reaches zero
module repeat_down_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign last = cnt == W'(1);

endmodule

// File: rtl/repeat_timer.sv
// repeat_timer: waits req_num clock edges after accepting a request, then offers a completion
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/req_ready/req_num : request handshake and edge count
//   abort                       : cancels a count in progress, no completion
//   busy                        : counting or completion pending
//   done_valid/done_ready       : completion handshake
//   done_num                    : req_num of the completed request
//   remaining                   : edges still to wait, 0 outside COUNT
module repeat_timer
    import repeat_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_num,
    input  logic             abort,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CNT_W-1:0] done_num,
    output logic [CNT_W-1:0] remaining
);

    state_t state;
    logic   accept;
    logic   counting;
    logic   kill;
    logic   cnt_last;

    assign accept   = state == IDLE && req_valid;
    assign counting = state == COUNT;
    assign kill     = counting && abort;

    repeat_down_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (req_num),
        .clear    (kill),
        .dec      (counting),
        .cnt      (remaining),
        .last     (cnt_last)
    );

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;

    // Abort is tested before cnt_last so it wins over the final decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done_valid <= 1'b0;
            done_num   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    done_num <= req_num;
                    if (req_num == '0) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                    end else begin
                        state <= COUNT;
                    end
                end
                COUNT: if (abort) begin
                    state <= IDLE;
                end else if (cnt_last) begin
                    state      <= DONE;
                    done_valid <= 1'b1;
                end
                DONE: if (done_ready) begin
                    state      <= IDLE;
                    done_valid <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    done_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repeat_timer.sv
// tb_repeat_timer: table-driven and scoreboarded checks of repeat_timer
module tb_repeat_timer;

    typedef struct packed {
        logic       rdy;
        logic       busy;
        logic       dv;
        logic [2:0] dn;
        logic [2:0] rem;
    } out_t;

    typedef struct {
        logic       rst;
        logic       rv;
        logic [2:0] num;
        logic       ab;
        logic       dr;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_num = '0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done_valid;
    logic       done_ready = 1'b0;
    logic [2:0] done_num;
    logic [2:0] remaining;

    int   checks = 0;
    int   errors = 0;
    out_t sb[$];
    vec_t tbl[$];

    always #10 clk = ~clk;

    repeat_timer #(.CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_num    (req_num),
        .abort      (abort),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_num   (done_num),
        .remaining  (remaining)
    );

    function automatic vec_t v(logic r, logic rv, logic [2:0] num, logic ab, logic dr,
                               logic rdy, logic b, logic dv, logic [2:0] dn, logic [2:0] rem);
        vec_t t;
        t.rst = r; t.rv = rv; t.num = num; t.ab = ab; t.dr = dr;
        t.exp = '{rdy: rdy, busy: b, dv: dv, dn: dn, rem: rem};
        return t;
    endfunction

    task automatic step(input vec_t t, input string nm);
        out_t got, exp;
        rst = t.rst; req_valid = t.rv; req_num = t.num; abort = t.ab; done_ready = t.dr;
        sb.push_back(t.exp);
        @(posedge clk);
        #1;
        got = '{rdy: req_ready, busy: busy, dv: done_valid, dn: done_num, rem: remaining};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got rdy=%b busy=%b dv=%b dn=%0d rem=%0d, want rdy=%b busy=%b dv=%b dn=%0d rem=%0d",
                     nm, $time, got.rdy, got.busy, got.dv, got.dn, got.rem,
                     exp.rdy, exp.busy, exp.dv, exp.dn, exp.rem);
        end
    endtask

    // Accept n, count down, rise done after exactly n edges, hold it for `hold` cycles, then consume.
    task automatic run_count(input logic [2:0] n, input int hold);
        longint t0, el;
        step(v(0, 1, n, 0, 0, 0, 1, 0, n, n), "accept");
        t0 = $time;
        for (int r = int'(n) - 1; r >= 1; r--)
            step(v(0, 0, 0, 0, 0, 0, 1, 0, n, 3'(r)), "count");
        step(v(0, 1, 3'd2, 0, 0, 0, 1, 1, n, 0), "done_rise");
        el = longint'($time) - t0;
        checks++;
        if (el != 64'(20 * int'(n))) begin
            errors++;
            $display("FAIL done_latency: got %0d, want %0d", el, 20 * int'(n));
        end
        for (int i = 0; i < hold; i++)
            step(v(0, 1, 3'd1, 0, 0, 0, 1, 1, n, 0), "done_hold");
        step(v(0, 0, 0, 0, 1, 1, 0, 0, n, 0), "done_pop");
    endtask

    initial begin
        //                rst rv num ab dr   rdy b dv dn rem
        tbl.push_back(v(1, 1, 3, 0, 0,   1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 4, 0, 0,   0, 1, 0, 4, 4));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 4, 3));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 4, 2));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 4, 1));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 1, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 0, 0, 4, 0));
        tbl.push_back(v(0, 1, 0, 0, 1,   0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5, 0, 0,   0, 1, 0, 5, 5));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 5, 4));
        tbl.push_back(v(0, 0, 0, 1, 0,   1, 0, 0, 5, 0));
        tbl.push_back(v(0, 1, 2, 0, 0,   0, 1, 0, 2, 2));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 2, 1));
        tbl.push_back(v(0, 0, 0, 1, 0,   1, 0, 0, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 0, 0, 2, 0));
        tbl.push_back(v(0, 1, 1, 1, 0,   0, 1, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 1, 1, 0));
        tbl.push_back(v(0, 1, 3, 1, 0,   0, 1, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 6, 0, 0,   0, 1, 0, 6, 6));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 6, 5));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 6, 4));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 6, 3));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 0, 6, 2));
        tbl.push_back(v(1, 0, 0, 0, 0,   1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0,   0, 1, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0,   0, 1, 1, 1, 0));
        tbl.push_back(v(1, 1, 5, 0, 0,   1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1,   1, 0, 0, 0, 0));
        foreach (tbl[i])
            step(tbl[i], $sformatf("vec%0d", i));
        run_count(3'd4, 0);
        run_count(3'd7, 5);
        run_count(3'd1, 1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
